// File: rtl/trivium_pkg.sv
// Shared definitions for the trivium keystream consumer: word width, warm-up
// length and the consumer FSM state encoding.
package trivium_pkg;

    localparam int TRIVIUM_WARMUP = 1152;
    localparam int TRIVIUM_WORD_W = 8;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        FILL    = 2'd1,
        KEY_RDY = 2'd2
    } xor_state_e;

endpackage : trivium_pkg

// File: rtl/trivium_stream_xor_ks_deserializer.sv
// Gathers DATA_W serial keystream bits (LSB first) into one keystream word.
// Each enable returns its bit one cycle later, so capture trails issue by a cycle.
module ks_deserializer
    import trivium_pkg::*;
#(
    parameter int DATA_W = TRIVIUM_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ks_bit,
    output logic              fill_en,
    output logic              done,
    output logic [DATA_W-1:0] kbuf
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  got_q, got_d;
    logic              cap_q, cap_d;
    logic [DATA_W-1:0] kbuf_q, kbuf_d;

    always_comb begin
        issued_d = issued_q;
        got_d    = got_q;
        kbuf_d   = kbuf_q;
        done     = 1'b0;
        fill_en  = start && (issued_q < CNT_W'(DATA_W));
        cap_d    = fill_en;

        if (fill_en) begin
            issued_d = issued_q + CNT_W'(1);
        end

        if (cap_q) begin
            kbuf_d[got_q[IDX_W-1:0]] = ks_bit;
            if (got_q == CNT_W'(DATA_W - 1)) begin
                // Last bit of the word: rearm both counters for the next fill.
                done     = 1'b1;
                got_d    = '0;
                issued_d = '0;
            end else begin
                got_d = got_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            got_q    <= '0;
            cap_q    <= 1'b0;
            kbuf_q   <= '0;
        end else begin
            issued_q <= issued_d;
            got_q    <= got_d;
            cap_q    <= cap_d;
            kbuf_q   <= kbuf_d;
        end
    end

    assign kbuf = kbuf_q;

endmodule : ks_deserializer

// File: rtl/trivium_stream_xor.sv
// Trivium keystream consumer: discards warm-up rounds, packs keystream words and
// XORs them onto a valid/ready data stream with a registered output stage.
//   state   | meaning
//   WARMUP  | stepping generator through its initialisation rounds
//   FILL    | issuing/capturing DATA_W keystream bits into kbuf
//   KEY_RDY | keystream word held, waiting for an input word
module trivium_stream_xor
    import trivium_pkg::*;
#(
    parameter int WARMUP_CYCLES = TRIVIUM_WARMUP,
    parameter int DATA_W        = TRIVIUM_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ks_en,
    input  logic              ks_bit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       word_cnt
);

    localparam int WC_W = $clog2(WARMUP_CYCLES + 1);

    xor_state_e        state_q, state_d;
    logic [WC_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [15:0]       word_cnt_q, word_cnt_d;

    logic              fill_start;
    logic              fill_en;
    logic              fill_done;
    logic [DATA_W-1:0] kbuf;
    logic              load;

    ks_deserializer #(
        .DATA_W (DATA_W)
    ) u_deser (
        .clk     (clk),
        .rst     (rst),
        .start   (fill_start),
        .ks_bit  (ks_bit),
        .fill_en (fill_en),
        .done    (fill_done),
        .kbuf    (kbuf)
    );

    assign fill_start = (state_q == FILL);
    assign ks_en      = (state_q == WARMUP) || fill_en;
    // Ready looks only at the output register, never at in_valid.
    assign in_ready   = (state_q == KEY_RDY) && (!out_valid_q || out_ready);
    assign load       = in_ready && in_valid;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;

        case (state_q)
            WARMUP: begin
                warm_cnt_d = warm_cnt_q + WC_W'(1);
                if (warm_cnt_q == WC_W'(WARMUP_CYCLES - 1)) begin
                    warm_cnt_d = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (fill_done) begin
                    state_d = KEY_RDY;
                end
            end
            KEY_RDY: begin
                if (load) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d    = WARMUP;
                warm_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        word_cnt_d  = word_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // A load in the same cycle as a drain wins and keeps the word valid.
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ kbuf;
            word_cnt_d  = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WARMUP;
            warm_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign word_cnt  = word_cnt_q;

endmodule : trivium_stream_xor

// File: tb/tb_trivium_stream_xor.sv
// Bench for trivium_stream_xor: a behavioural trivium generator feeds the block and
// expected words are taken from the precomputed trivium keystream.
module tb_trivium_stream_xor;

    localparam int NZ = 4096;
    localparam int WU = 1152;

    logic       clk;
    logic       rst;
    logic       ks_en;
    logic       ks_bit;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [15:0] word_cnt;

    int checks;
    int errors;

    bit z_arr [NZ];
    int gen_idx;

    int cyc;
    int ks_cnt;
    int first_rdy;
    int ks_at_rdy;
    int acc_cyc;
    logic [7:0] acc_q[$];
    logic [7:0] out_q[$];
    int         out_cyc_q[$];
    logic [7:0] in_words[$];

    trivium_stream_xor dut (
        .clk       (clk),
        .rst       (rst),
        .ks_en     (ks_en),
        .ks_bit    (ks_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator stand-in: registered output, one trivium round per enable.
    always @(posedge clk) begin
        if (rst) begin
            gen_idx <= 0;
            ks_bit  <= 1'b0;
        end else if (ks_en) begin
            ks_bit  <= z_arr[gen_idx % NZ];
            gen_idx <= gen_idx + 1;
        end
    end

    task automatic gen_keystream();
        bit s [1:288];
        bit t1, t2, t3;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = 1'($urandom_range(0, 1));
            s[93 + i] = 1'($urandom_range(0, 1));
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int k = 0; k < NZ; k++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z_arr[k] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 93; i >= 2; i--) s[i] = s[i-1];
            s[1] = t3;
            for (int i = 177; i >= 95; i--) s[i] = s[i-1];
            s[94] = t1;
            for (int i = 288; i >= 179; i--) s[i] = s[i-1];
            s[178] = t2;
        end
    endtask

    // Keystream word j: generator outputs WU+8j .. WU+8j+7, first bit in bit 0.
    function automatic logic [7:0] kbyte(input int j);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = z_arr[WU + 8*j + b];
        return r;
    endfunction

    task automatic clear_book();
        cyc = 0; ks_cnt = 0; first_rdy = -1; ks_at_rdy = -1; acc_cyc = -1;
        acc_q.delete(); out_q.delete(); out_cyc_q.delete();
    endtask

    task automatic observe();
        #1;
        if (!rst) begin
            if (in_ready && first_rdy < 0) begin
                first_rdy = cyc;
                ks_at_rdy = ks_cnt;
            end
            if (ks_en) ks_cnt++;
            if (in_valid && in_ready) begin
                acc_q.push_back(in_data);
                acc_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                out_cyc_q.push_back(cyc);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        advance();
        advance();
        rst = 1'b0;
        clear_book();
    endtask

    task automatic run_stream(input int n, input bit rand_valid);
        int guard;
        guard = 0;
        while (out_q.size() < n && guard < 8000) begin
            in_valid  = (acc_q.size() < n) && (rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
            in_data   = (acc_q.size() < n) ? in_words[acc_q.size()] : 8'h00;
            out_ready = 1'b1;
            observe();
            advance();
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (out_q.size() < n) begin
            errors++;
            $display("FAIL stream_timeout: got %0d words required %0d", out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        advance();
        advance();
        #1;
        checks += 5;
        if (ks_en !== 1'b1) begin errors++; $display("FAIL rst_ks_en: got %b required 1", ks_en); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h required 00", out_data); end
        if (word_cnt !== 16'd0) begin errors++; $display("FAIL rst_word_cnt: got %0d required 0", word_cnt); end
    endtask

    task automatic test_first_word();
        do_reset();
        in_words.delete();
        in_words.push_back(8'h00);
        run_stream(1, 1'b0);
        checks += 3;
        if (first_rdy !== 1161) begin errors++; $display("FAIL t1_first_ready: got %0d required 1161", first_rdy); end
        if (ks_at_rdy !== 1160) begin errors++; $display("FAIL t1_ks_en_count: got %0d required 1160", ks_at_rdy); end
        if (out_q.size() > 0 && out_q[0] !== kbyte(0)) begin
            errors++; $display("FAIL t1_word0: got %h required %h", out_q[0], kbyte(0));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_words.delete();
        for (int i = 0; i < 16; i++) in_words.push_back(8'(i));
        run_stream(16, 1'b0);
        for (int i = 0; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== (kbyte(i) ^ 8'(i))) begin
                errors++; $display("FAIL t2_word%0d: got %h required %h", i, out_q[i], kbyte(i) ^ 8'(i));
            end
            if (i > 0) begin
                checks++;
                if (out_cyc_q[i] - out_cyc_q[i-1] != 10) begin
                    errors++; $display("FAIL t2_spacing%0d: got %0d required 10", i, out_cyc_q[i] - out_cyc_q[i-1]);
                end
            end
        end
        #1;
        checks++;
        if (word_cnt !== 16'd16) begin errors++; $display("FAIL t2_word_cnt: got %0d required 16", word_cnt); end
    endtask

    task automatic test_roundtrip();
        logic [7:0] ct[$];
        do_reset();
        in_words.delete();
        in_words.push_back(8'hA5);
        in_words.push_back(8'h3C);
        run_stream(2, 1'b0);
        ct = out_q;
        do_reset();
        in_words = ct;
        run_stream(2, 1'b0);
        checks += 2;
        if (out_q.size() < 2 || out_q[0] !== 8'hA5) begin
            errors++; $display("FAIL t3_dec0: got %h required a5", (out_q.size() > 0) ? out_q[0] : 8'hxx);
        end
        if (out_q.size() < 2 || out_q[1] !== 8'h3C) begin
            errors++; $display("FAIL t3_dec1: got %h required 3c", (out_q.size() > 1) ? out_q[1] : 8'hxx);
        end
    endtask

    task automatic test_stall();
        logic [7:0] d0, d1, snap;
        int guard;
        bit seen;
        d0 = 8'($urandom); d1 = 8'($urandom);
        do_reset();
        guard = 0; seen = 1'b0;
        while (!seen && guard < 2000) begin
            in_valid = (acc_q.size() == 0); in_data = d0; out_ready = 1'b0;
            observe();
            if (out_valid) seen = 1'b1;
            else begin advance(); guard++; end
        end
        checks += 2;
        if (!seen) begin errors++; $display("FAIL t4_timeout: got no output required one"); end
        snap = out_data;
        if (snap !== (kbyte(0) ^ d0)) begin errors++; $display("FAIL t4_word0: got %h required %h", snap, kbyte(0) ^ d0); end
        for (int i = 0; i < 50; i++) begin
            advance();
            in_valid = 1'b1; in_data = d1; out_ready = 1'b0;
            observe();
            checks++;
            if (out_valid !== 1'b1 || out_data !== snap) begin
                errors++; $display("FAIL t4_hold%0d: got %b/%h required 1/%h", i, out_valid, out_data, snap);
            end
        end
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL t4_in_ready: got %b required 0", in_ready); end
        if (ks_cnt !== 1168) begin errors++; $display("FAIL t4_ks_en_count: got %0d required 1168", ks_cnt); end
        advance();
        in_valid = 1'b1; in_data = d1; out_ready = 1'b1;
        observe();
        advance();
        in_valid = 1'b0; out_ready = 1'b0;
        observe();
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL t4_reload_valid: got %b required 1", out_valid); end
        if (out_data !== (kbyte(1) ^ d1)) begin errors++; $display("FAIL t4_word1: got %h required %h", out_data, kbyte(1) ^ d1); end
        if (word_cnt !== 16'd2) begin errors++; $display("FAIL t4_word_cnt: got %0d required 2", word_cnt); end
    endtask

    task automatic test_mid_reset();
        int guard;
        do_reset();
        guard = 0;
        while (acc_q.size() == 0 && guard < 2000) begin
            in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
            observe();
            if (acc_q.size() == 0) begin advance(); guard++; end
        end
        advance();
        while (cyc < acc_cyc + 6 && guard < 4000) begin
            in_valid = 1'b0; out_ready = 1'b0;
            observe();
            advance();
            guard++;
        end
        #0;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL t5_pre_valid: got %b required 1", out_valid); end
        if (word_cnt !== 16'd1) begin errors++; $display("FAIL t5_pre_word_cnt: got %0d required 1", word_cnt); end
        rst = 1'b1;
        advance();
        rst = 1'b0;
        clear_book();
        observe();
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_out_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL t5_in_ready: got %b required 0", in_ready); end
        if (ks_en !== 1'b1) begin errors++; $display("FAIL t5_ks_en: got %b required 1", ks_en); end
        if (word_cnt !== 16'd0) begin errors++; $display("FAIL t5_word_cnt: got %0d required 0", word_cnt); end
        advance();
        in_words.delete();
        in_words.push_back(8'h77);
        run_stream(1, 1'b0);
        checks += 2;
        if (ks_at_rdy !== 1160) begin errors++; $display("FAIL t5_ks_en_count: got %0d required 1160", ks_at_rdy); end
        if (out_q.size() > 0 && out_q[0] !== (kbyte(0) ^ 8'h77)) begin
            errors++; $display("FAIL t5_word0: got %h required %h", out_q[0], kbyte(0) ^ 8'h77);
        end
    endtask

    task automatic test_random_valid();
        do_reset();
        in_words.delete();
        for (int i = 0; i < 200; i++) in_words.push_back(8'($urandom));
        run_stream(200, 1'b1);
        for (int i = 0; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== (kbyte(i) ^ in_words[i])) begin
                errors++; $display("FAIL t6_word%0d: got %h required %h", i, out_q[i], kbyte(i) ^ in_words[i]);
            end
        end
        #1;
        checks++;
        if (word_cnt !== 16'd200) begin errors++; $display("FAIL t6_word_cnt: got %0d required 200", word_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        clear_book();
        gen_keystream();
        test_reset();
        test_first_word();
        test_back_to_back();
        test_roundtrip();
        test_stall();
        test_mid_reset();
        test_random_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_trivium_stream_xor
